// File: rtl/controle_nivel_pkg.sv
// Shared types and level-code helpers for the tank level controller.
package controle_nivel_pkg;

  typedef enum logic [2:0] {
    DESLIGADO = 3'd0,
    VAZIO     = 3'd1,
    ENCHENDO  = 3'd2,
    ESTAVEL   = 3'd3,
    CHEIO     = 3'd4,
    ERRO      = 3'd5
  } estado_t;

  localparam logic [2:0] NIV_VAZIO = 3'b000;
  localparam logic [2:0] NIV_BAIXO = 3'b001;
  localparam logic [2:0] NIV_MEDIO = 3'b011;
  localparam logic [2:0] NIV_CHEIO = 3'b111;

  // Sensors stack physically, so only "thermometer" codes {z,y,x} are legal.
  function automatic logic is_valid_level(input logic [2:0] niv);
    return (niv == NIV_VAZIO) || (niv == NIV_BAIXO) ||
           (niv == NIV_MEDIO) || (niv == NIV_CHEIO);
  endfunction

endpackage

// File: rtl/controle_nivel_debounce.sv
// Two-flop synchroniser plus stability counter for one raw level sensor.
module debounce_sensor #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int            CW      = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only advances while the synced input disagrees with the output;
  // any agreement (including a glitch ending) restarts the stability window.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/controle_nivel.sv
// Tank level control: sensor conditioning, pump hysteresis/fault FSM and
// blink clock feeding the LED/buzzer indicator stage.
module controle_nivel
  import controle_nivel_pkg::*;
#(
  parameter int DEB_CYCLES = 50000,
  parameter int BLINK_DIV  = 25000000,
  parameter int ERR_HOLD   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic liga,
  input  logic sx,
  input  logic sy,
  input  logic sz,
  output logic x,
  output logic y,
  output logic z,
  output logic p,
  output logic o,
  output logic e,
  output logic pisca,
  output logic bomba
);

  localparam int            BW       = $clog2(BLINK_DIV + 1);
  localparam logic [BW-1:0] BLK_MAX  = BW'(BLINK_DIV - 1);
  localparam int            EW       = $clog2(ERR_HOLD + 1);
  localparam logic [EW-1:0] ERR_MAX  = EW'(ERR_HOLD - 1);

  logic          x_w, y_w, z_w;
  logic [2:0]    niv;
  logic          niv_ok;
  logic          ativo;

  logic          liga_s1_q, liga_s1_d;
  logic          e_q, e_d;
  estado_t       state_q, state_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic [BW-1:0] blk_cnt_q, blk_cnt_d;
  logic          pisca_q, pisca_d;
  logic          p_q, p_d;
  logic          o_q, o_d;
  logic          bomba_q, bomba_d;

  debounce_sensor #(.DEB_CYCLES(DEB_CYCLES)) u_deb_x (
    .clk(clk), .rst_n(rst_n), .raw(sx), .level(x_w)
  );
  debounce_sensor #(.DEB_CYCLES(DEB_CYCLES)) u_deb_y (
    .clk(clk), .rst_n(rst_n), .raw(sy), .level(y_w)
  );
  debounce_sensor #(.DEB_CYCLES(DEB_CYCLES)) u_deb_z (
    .clk(clk), .rst_n(rst_n), .raw(sz), .level(z_w)
  );

  assign niv    = {z_w, y_w, x_w};
  assign niv_ok = is_valid_level(niv);
  assign ativo  = (state_q == VAZIO) || (state_q == ENCHENDO) ||
                  (state_q == ESTAVEL) || (state_q == CHEIO);

  // liga is a level switch, so it is only synchronised, never debounced.
  always_comb begin
    liga_s1_d = liga;
    e_d       = liga_s1_q;
  end

  // Free-running blink divider, unrelated to the FSM.
  always_comb begin
    pisca_d   = pisca_q;
    blk_cnt_d = blk_cnt_q + BW'(1);
    if (blk_cnt_q == BLK_MAX) begin
      blk_cnt_d = '0;
      pisca_d   = ~pisca_q;
    end
  end

  // Counts consecutive invalid codes while the FSM is running.
  always_comb begin
    err_cnt_d = '0;
    if (e_q && ativo && !niv_ok && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + EW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DESLIGADO;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!e_q) begin
      state_d = DESLIGADO;
    end else if (ativo && !niv_ok && (err_cnt_q == ERR_MAX)) begin
      state_d = ERRO;
    end else begin
      case (state_q)
        DESLIGADO: begin
          if (niv == NIV_VAZIO)      state_d = VAZIO;
          else if (niv == NIV_CHEIO) state_d = CHEIO;
          else                       state_d = ESTAVEL;
        end
        VAZIO: begin
          if (niv != NIV_VAZIO) state_d = ENCHENDO;
        end
        ENCHENDO: begin
          if (niv == NIV_CHEIO)      state_d = CHEIO;
          else if (niv == NIV_VAZIO) state_d = VAZIO;
        end
        CHEIO: begin
          if (niv != NIV_CHEIO) state_d = ESTAVEL;
        end
        // Hysteresis: once the pump stops it restarts only at empty.
        ESTAVEL: begin
          if (niv == NIV_VAZIO)      state_d = VAZIO;
          else if (niv == NIV_CHEIO) state_d = CHEIO;
        end
        ERRO:    state_d = ERRO;
        default: state_d = DESLIGADO;
      endcase
    end
  end

  always_comb begin
    p_d     = (state_q == ERRO);
    o_d     = (state_q == CHEIO);
    bomba_d = (state_q == VAZIO) || (state_q == ENCHENDO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      liga_s1_q <= 1'b0;
      e_q       <= 1'b0;
      err_cnt_q <= '0;
      blk_cnt_q <= '0;
      pisca_q   <= 1'b0;
      p_q       <= 1'b0;
      o_q       <= 1'b0;
      bomba_q   <= 1'b0;
    end else begin
      liga_s1_q <= liga_s1_d;
      e_q       <= e_d;
      err_cnt_q <= err_cnt_d;
      blk_cnt_q <= blk_cnt_d;
      pisca_q   <= pisca_d;
      p_q       <= p_d;
      o_q       <= o_d;
      bomba_q   <= bomba_d;
    end
  end

  assign x     = x_w;
  assign y     = y_w;
  assign z     = z_w;
  assign p     = p_q;
  assign o     = o_q;
  assign e     = e_q;
  assign pisca = pisca_q;
  assign bomba = bomba_q;

endmodule

// File: tb/tb_controle_nivel.sv
// Directed bench for controle_nivel with short debounce/blink parameters.
module tb_controle_nivel;

  logic clk = 1'b0;
  logic rst_n, liga, sx, sy, sz;
  logic x, y, z, p, o, e, pisca, bomba;

  int n_chk = 0;
  int n_err = 0;

  controle_nivel #(.DEB_CYCLES(4), .BLINK_DIV(8), .ERR_HOLD(3)) dut (
    .clk(clk), .rst_n(rst_n), .liga(liga),
    .sx(sx), .sy(sy), .sz(sz),
    .x(x), .y(y), .z(z), .p(p), .o(o), .e(e),
    .pisca(pisca), .bomba(bomba)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n active edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; liga = 1'b0; sx = 1'b0; sy = 1'b0; sz = 1'b0;
    tick(3);
    check("reset_outs", {x, y, z, p, o, e, pisca, bomba}, 8'h00);

    // Release reset with liga on and tank empty (t=0 here).
    rst_n = 1'b1; liga = 1'b1;
    tick(1); check("e_sync_1", e, 1'b0);
    tick(1); check("e_sync_2", e, 1'b1);
    check("bomba_desl", bomba, 1'b0);
    tick(1); check("bomba_lat", bomba, 1'b0);
    tick(1); check("vazio_outs", {p, o, bomba}, 3'b001);
    tick(3); check("pisca_t7", pisca, 1'b0);
    tick(1); check("pisca_t8", pisca, 1'b1);
    tick(7); check("pisca_t15", pisca, 1'b1);
    tick(1); check("pisca_t16", pisca, 1'b0);

    // Fill: each debounced level rises 6 edges after its raw edge.
    sx = 1'b1;
    tick(5); check("x_early", x, 1'b0);
    tick(1); check("x_rise", x, 1'b1);
    tick(14); check("bomba_ench_x", bomba, 1'b1);
    sy = 1'b1;
    tick(5); check("y_early", y, 1'b0);
    tick(1); check("y_rise", y, 1'b1);
    tick(14); check("bomba_ench_y", bomba, 1'b1);
    sz = 1'b1;
    tick(5); check("z_early", z, 1'b0);
    tick(1); check("z_rise", z, 1'b1);
    tick(1); check("cheio_lat", {o, bomba}, 2'b01);
    tick(1); check("cheio_outs", {p, o, bomba}, 3'b010);

    // Drain to 011: leave CHEIO into ESTAVEL, pump stays off.
    sz = 1'b0;
    tick(6); check("z_fall", z, 1'b0);
    tick(2); check("estavel_011", {p, o, bomba}, 3'b000);

    // Three-cycle glitch on sz must be filtered out.
    sz = 1'b1;
    tick(3);
    sz = 1'b0;
    tick(10);
    check("glitch_z", z, 1'b0);
    check("glitch_state", {p, o, bomba}, 3'b000);

    sy = 1'b0;
    tick(6); check("y_fall", y, 1'b0);
    tick(2); check("estavel_001", {p, o, bomba}, 3'b000);
    sx = 1'b0;
    tick(6); check("x_fall", x, 1'b0);
    tick(1); check("vazio_lat", bomba, 1'b0);
    tick(1); check("bomba_restart", bomba, 1'b1);

    // Invalid code 100: ENCHENDO briefly, then ERRO after 3 invalid cycles.
    sz = 1'b1;
    tick(6); check("z_inval", {z, y, x}, 3'b100);
    tick(3); check("pre_erro", {p, bomba}, 2'b01);
    tick(1); check("erro_outs", {p, o, bomba}, 3'b100);

    // Back to a valid code: ERRO is sticky.
    sz = 1'b0; sx = 1'b1;
    tick(6); check("lvl_001", {z, y, x}, 3'b001);
    tick(4); check("erro_sticky", {p, o, bomba}, 3'b100);

    // Pulse liga to leave ERRO, then re-enter as ESTAVEL.
    liga = 1'b0;
    tick(4); check("liga_off", {e, p, bomba}, 3'b000);
    liga = 1'b1;
    tick(2); check("liga_on", e, 1'b1);
    tick(2); check("reentry_estavel", {p, o, bomba}, 3'b000);

    // Empty again so the pump runs, then reset mid-operation.
    sx = 1'b0;
    tick(8); check("bomba_pre_rst", bomba, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {x, y, z, p, o, e, pisca, bomba}, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1); check("rst_e_1", {e, bomba}, 2'b00);
    tick(1); check("rst_e_2", {e, bomba}, 2'b10);
    tick(2); check("rst_vazio", bomba, 1'b1);
    tick(3); check("rst_pisca_t7", pisca, 1'b0);
    tick(1); check("rst_pisca_t8", pisca, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
